alu_control_md: RTL and testbench
=================================

# alu_control_md

Parametrised next-generation ALU control for the 32-bit MIPS datapath. It decodes `ALUOp` and the full 6-bit funct field into the 4-bit ALU code. It also owns an iterative multiply/divide engine with HI/LO registers for `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo`. It sits in EX beside the ALU, selects the EX result source, and stalls the pipeline while an iteration is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand/HI/LO width; iteration count.
- `FUNCT_W`, 6: funct field width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ALUOp`  in  2  main-control op class.
- `Funct`  in  FUNCT_W  instruction[5:0].
- `start`  in  1  EX holds a valid instruction this cycle.
- `a`, `b`  in  WIDTH  rs / rt operand values.
- `ALUInput`  out  4  ALU operation code (combinational).
- `hilo_sel`  out  2  EX result mux: 00 ALU, 01 HI, 10 LO (combinational).
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `busy`  out  1  multiply/divide iteration in progress (registered).
- `done`  out  1  one-cycle pulse when HI/LO take a mul/div result (registered).
- `stall`  out  1  hold IF/ID/EX this cycle (combinational).

## Operation
ALUInput decode. There are no don't-care matches; every bit of `Funct` is compared.
- `ALUOp` 00 → 0010 (add, lw/sw).
- `ALUOp` 01 → 0110 (sub, beq/bne).
- `ALUOp` 11 → 0010.
- `ALUOp` 10, R-type, decoded on `Funct`:
  - 100000 / 100001 → 0010
  - 100010 / 100011 → 0110
  - 100100 → 0000
  - 100101 → 0001
  - 100110 → 0100
  - 100111 → 0011
  - 101010 → 0111
  - mul/div and HI/LO functs → 0010
  - any other funct → 1111. This is never X.

`hilo_sel`:
- 01 when `ALUOp`=10 and `Funct`=010000 (mfhi).
- 10 when `ALUOp`=10 and `Funct`=010010 (mflo).
- 00 otherwise.

Engine FSM has three states: IDLE, ITER, FIN.
- IDLE → ITER: on `start` & `ALUOp`=10 & `Funct` ∈ {011000 mult, 011001 multu, 011010 div, 011011 divu}.
  - Latch the magnitudes of `a`/`b` (two's-complement abs for the signed ops), the result signs, and the op.
  - Clear the iteration counter.
- ITER: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
  - After WIDTH steps → FIN.
- FIN: apply sign correction and write HI/LO.
  - Assert `done` for the following cycle, then → IDLE.
- mthi (010001) / mtlo (010011) with `start` in IDLE: HI or LO ← `a` at that edge; `done` is not pulsed.

Arithmetic rules:
- Multiply: {HI,LO} = 2·WIDTH-bit product. Signed result is negated iff the operand signs differ.
- Divide: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (signed or unsigned): LO = all ones, HI = `a`. There is no trap.
- Signed MIN / −1: LO = MIN, HI = 0.

Stall rules:
- `stall` = `busy` & `start` & (`ALUOp`=10) & `Funct` ∈ {mul/div, mfhi, mflo, mthi, mtlo}.
- Non-HI/LO instructions continue while the engine runs.
- A stalled instruction is not accepted; it re-presents `start` and is accepted the cycle after `busy` falls.
- mfhi/mflo in that cycle read the new HI/LO.

## Timing
- Reset (`rst_n`=0 at an edge), from any state including mid-ITER:
  - state IDLE, counter 0.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - the in-flight operation is discarded.
- Mul/div latency. Let edge E0 be the edge that accepts the op.
  - `busy`=1 from after E0 through the cycle ending at E(WIDTH+1).
  - HI/LO are updated at E(WIDTH+1).
  - `busy`=0 and `done`=1 in the cycle after E(WIDTH+1).
  - Total occupancy is WIDTH+1 cycles (33 at default).
- Back-to-back: a new mul/div may be accepted at the edge ending the `done` cycle.
- mthi/mtlo: HI/LO visible the cycle after the accepting edge. They are not accepted while `busy`.
- `start` with a mul/div op while `busy`: ignored, and `stall`=1.
- `ALUInput`, `hilo_sel` and `stall` are purely combinational. There is no clock latency.

## Test plan
- Reset, then decode sweep: `ALUOp`=01 → 0110; `Funct`=100111 → 0011; 100110 → 0100; 010000 → `hilo_sel`=01; 111111 → 1111. All outputs are 0 after reset.
- multu a=b=0xFFFFFFFF → after 33 busy cycles, hi=0xFFFFFFFE, lo=0x00000001, `done` high exactly one cycle.
- mult a=−3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x00001234. div a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- mfhi presented 3 cycles after mult start → `stall`=1 every cycle until `busy` falls. An add presented during `busy` → `stall`=0.
- Drive `rst_n` low at iteration 10 of a div → next cycle `busy`=0, hi=lo=0. A fresh mthi a=0xA5A5A5A5 is then accepted → hi=0xA5A5A5A5 one cycle later.

Source files
------------

// File: rtl/alu_control_md.sv
// ALU control decode with an iterative multiply/divide engine owning HI/LO.
// Mul/div occupy the engine for WIDTH+1 cycles; HI/LO users stall meanwhile.
module alu_control_md #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [3:0]         ALUInput,
    output logic [1:0]         hilo_sel,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
    output logic               stall
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
    localparam logic [FUNCT_W-1:0] F_MTHI  = FUNCT_W'(6'b010001);
    localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
    localparam logic [FUNCT_W-1:0] F_MTLO  = FUNCT_W'(6'b010011);
    localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
    localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
    localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, q_q, m_q, a_q, hi_q, lo_q;
    logic             is_div_q, neg_q_q, neg_r_q, dz_q, done_q;

    logic             rtype, is_md, is_hilo, accept;
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] ma, mb, addend, acc_step, q_step;
    logic [WIDTH:0]   madd, dshift, dsub;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign rtype   = (ALUOp == 2'b10);
    assign is_md   = rtype && (Funct == F_MULT || Funct == F_MULTU ||
                               Funct == F_DIV  || Funct == F_DIVU);
    assign is_hilo = rtype && (Funct == F_MFHI || Funct == F_MTHI ||
                               Funct == F_MFLO || Funct == F_MTLO);
    assign accept  = start && is_md && (state_q == S_IDLE);

    always_comb begin
        ALUInput = 4'b1111;
        case (ALUOp)
            2'b00: ALUInput = 4'b0010;
            2'b01: ALUInput = 4'b0110;
            2'b11: ALUInput = 4'b0010;
            default: begin
                case (Funct)
                    FUNCT_W'(6'b100000), FUNCT_W'(6'b100001): ALUInput = 4'b0010;
                    FUNCT_W'(6'b100010), FUNCT_W'(6'b100011): ALUInput = 4'b0110;
                    FUNCT_W'(6'b100100): ALUInput = 4'b0000;
                    FUNCT_W'(6'b100101): ALUInput = 4'b0001;
                    FUNCT_W'(6'b100110): ALUInput = 4'b0100;
                    FUNCT_W'(6'b100111): ALUInput = 4'b0011;
                    FUNCT_W'(6'b101010): ALUInput = 4'b0111;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ALUInput = 4'b0010;
                    default: ALUInput = 4'b1111;
                endcase
            end
        endcase
    end

    always_comb begin
        hilo_sel = 2'b00;
        if (rtype && Funct == F_MFHI) hilo_sel = 2'b01;
        if (rtype && Funct == F_MFLO) hilo_sel = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_ITER;
            S_ITER: if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = done_q;
        stall = busy && start && (is_md || is_hilo);
        hi    = hi_q;
        lo    = lo_q;
    end

    // Operand magnitudes; unsigned ops never see a sign
    always_comb begin
        sgn = ~Funct[0];
        sa  = sgn & a[WIDTH-1];
        sb  = sgn & b[WIDTH-1];
        ma  = sa ? -a : a;
        mb  = sb ? -b : b;
    end

    always_comb begin
        addend = q_q[0] ? m_q : {WIDTH{1'b0}};
        madd   = {1'b0, acc_q} + {1'b0, addend};
        dshift = {acc_q, q_q[WIDTH-1]};
        dsub   = dshift - {1'b0, m_q};
        if (is_div_q) begin
            if (dshift >= {1'b0, m_q}) begin
                acc_step = dsub[WIDTH-1:0];
                q_step   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = dshift[WIDTH-1:0];
                q_step   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = madd[WIDTH:1];
            q_step   = {madd[0], q_q[WIDTH-1:1]};
        end
        prod = neg_q_q ? -{acc_q, q_q} : {acc_q, q_q};
        quo  = neg_q_q ? -q_q : q_q;
        rem  = neg_r_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= (state_q == S_FIN);
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        is_div_q <= Funct[1];
                        m_q      <= Funct[1] ? mb : ma;
                        q_q      <= Funct[1] ? ma : mb;
                        a_q      <= a;
                        neg_q_q  <= sa ^ sb;
                        neg_r_q  <= sa;
                        dz_q     <= (b == '0);
                    end else if (start && rtype && Funct == F_MTHI) begin
                        hi_q <= a;
                    end else if (start && rtype && Funct == F_MTLO) begin
                        lo_q <= a;
                    end
                end
                S_ITER: begin
                    acc_q <= acc_step;
                    q_q   <= q_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIN: begin
                    if (!is_div_q) begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: decode table, directed mul/div corners,
// stall and reset sequences, and random mul/div against a 64-bit model.
module tb_alu_control_md;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic        start;
    logic [31:0] a, b;
    logic [3:0]  ALUInput;
    logic [1:0]  hilo_sel;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int n_chk = 0;
    int n_fail = 0;

    alu_control_md dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct(Funct),
        .start(start), .a(a), .b(b), .ALUInput(ALUInput),
        .hilo_sel(hilo_sel), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] alu;
        logic [1:0] sel;
    } dec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {HI,LO} from plain arithmetic
    function automatic logic [63:0] model(input logic [5:0] f,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] ux, uy;
        longint      sp;
        int          sx, sy;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = x;
        sy = y;
        case (f)
            6'b011000: begin
                sp = longint'(sx) * longint'(sy);
                return sp;
            end
            6'b011001: return ux * uy;
            6'b011010: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    return {32'h0, 32'h80000000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle
    task automatic run_md(input string name, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [63:0] exp;
        exp = model(f, x, y);
        ALUOp = 2'b10; Funct = f; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; ALUOp = 2'b00;
        @(negedge clk);
        check({name, " done_clear"}, {63'd0, done}, 64'd0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 64'(n), 64'd33);
        check({name, " done"}, {63'd0, done}, 64'd1);
        check({name, " hilo"}, {hi, lo}, exp);
    endtask

    dec_t tbl[$];
    logic [5:0] rf;
    logic [31:0] ra, rb;

    initial begin
        tbl = '{
            '{2'b00, 6'b010000, 4'b0010, 2'b00},
            '{2'b01, 6'b100000, 4'b0110, 2'b00},
            '{2'b11, 6'b111111, 4'b0010, 2'b00},
            '{2'b10, 6'b100000, 4'b0010, 2'b00},
            '{2'b10, 6'b100001, 4'b0010, 2'b00},
            '{2'b10, 6'b100010, 4'b0110, 2'b00},
            '{2'b10, 6'b100011, 4'b0110, 2'b00},
            '{2'b10, 6'b100100, 4'b0000, 2'b00},
            '{2'b10, 6'b100101, 4'b0001, 2'b00},
            '{2'b10, 6'b100110, 4'b0100, 2'b00},
            '{2'b10, 6'b100111, 4'b0011, 2'b00},
            '{2'b10, 6'b101010, 4'b0111, 2'b00},
            '{2'b10, 6'b011000, 4'b0010, 2'b00},
            '{2'b10, 6'b011011, 4'b0010, 2'b00},
            '{2'b10, 6'b010000, 4'b0010, 2'b01},
            '{2'b10, 6'b010010, 4'b0010, 2'b10},
            '{2'b10, 6'b010001, 4'b0010, 2'b00},
            '{2'b10, 6'b111111, 4'b1111, 2'b00},
            '{2'b10, 6'b000000, 4'b1111, 2'b00},
            '{2'b10, 6'b101011, 4'b1111, 2'b00}
        };
        rst_n = 1'b0; start = 1'b0; ALUOp = 2'b00; Funct = 6'd0;
        a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_sel", {62'd0, hilo_sel}, 64'd0);

        foreach (tbl[i]) begin
            ALUOp = tbl[i].op; Funct = tbl[i].f;
            #1;
            check($sformatf("dec_alu[%0d]", i), {60'd0, ALUInput},
                  {60'd0, tbl[i].alu});
            check($sformatf("dec_sel[%0d]", i), {62'd0, hilo_sel},
                  {62'd0, tbl[i].sel});
        end
        ALUOp = 2'b00;
        @(negedge clk);

        run_md("multu_max", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_val", {hi, lo}, 64'hFFFFFFFE_00000001);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        run_md("mult_neg", 6'b011000, 32'hFFFFFFFD, 32'd5);
        check("mult_neg_val", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run_md("div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2);
        check("div_neg_val", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_md("divu_zero", 6'b011011, 32'h1234, 32'd0);
        check("divu_zero_val", {hi, lo}, 64'h00001234_FFFFFFFF);
        run_md("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_val", {hi, lo}, 64'h00000000_80000000);
        run_md("div_zero_s", 6'b011010, 32'hFFFFFF00, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rf = 6'b011000 | 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 0;
                1: rb = $urandom_range(1, 20);
                2: ra = $urandom_range(0, 1000);
                3: rb = -$urandom_range(1, 20);
                default: ;
            endcase
            run_md($sformatf("rand%0d", i), rf, ra, rb);
        end
        @(negedge clk);

        ALUOp = 2'b10; Funct = 6'b011000; a = 32'hFFFFFFFD; b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        ALUOp = 2'b10; Funct = 6'b100000; start = 1'b1;
        #1 check("add_no_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        Funct = 6'b010000;
        #1;
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                check("mfhi_stall", {63'd0, stall}, 64'd1);
                @(negedge clk);
                #1 n++;
            end
            check("mfhi_wait_bound", {63'd0, busy}, 64'd0);
        end
        check("mfhi_release", {63'd0, stall}, 64'd0);
        check("mfhi_sel", {62'd0, hilo_sel}, 64'd1);
        check("mfhi_new_hi", {32'd0, hi}, 64'hFFFFFFFF);
        @(posedge clk);
        #1 start = 1'b0; ALUOp = 2'b00;
        @(negedge clk);

        ALUOp = 2'b10; Funct = 6'b011010; a = 32'd1000; b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        ALUOp = 2'b10; Funct = 6'b010001; a = 32'hA5A5A5A5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'hA5A5A5A5);
        check("mthi_lo", {32'd0, lo}, 64'd0);
        check("mthi_no_done", {63'd0, done}, 64'd0);
        Funct = 6'b010011; a = 32'h5A5A0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mtlo_lo", {32'd0, lo}, 64'h5A5A0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
